// File: rtl/tow_pkg.sv
// Purpose: shared types for the tug-of-war arena (FSM states, winner codes).
// Latency: n/a, declarations only.
// Backpressure: n/a.
package tow_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,   // LEDs dark, waiting out the clear phase
        ARMED = 2'd1,   // marker lit, first press wins the round
        OVER  = 2'd2    // game decided, flashing the end LED until reset
    } state_t;

    localparam logic [1:0] W_NONE  = 2'b00;
    localparam logic [1:0] W_RIGHT = 2'b01;
    localparam logic [1:0] W_LEFT  = 2'b10;

endpackage

// File: rtl/tow_btn_sync.sv
// Purpose: 2-flop synchroniser plus rising-edge detector for one pushbutton.
// Latency: press is valid after the 2nd edge that samples pb high.
// Backpressure: none; a held button yields exactly one press.
// Ports: clk, rst (sync, active-low), pb (async button), press (1-cycle pulse).
module tow_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic press
);

    logic       sync_1;
    logic       sync_2;
    logic       prev;
    // Fills with ones after reset; masks the edge detector until prev holds a
    // real sample, so a button held through reset release is not a press.
    logic [2:0] live;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
            live   <= 3'b000;
        end else begin
            sync_1 <= pb;
            sync_2 <= sync_1;
            prev   <= sync_2;
            live   <= {live[1:0], 1'b1};
        end
    end

    assign press = sync_2 & ~prev & live[2];

endmodule

// File: rtl/tow_arena.sv
// Purpose: two-player tug-of-war on an N_LEDS bar (false starts, ties, flash on win).
// Latency: press visible on leds_out 3 edges after the button is first sampled high.
// Backpressure: none; buttons ignored in OVER, exit only via reset.
// Ports: clk, rst (sync, active-low), pbl/pbr (async buttons),
//        leds_out (N_LEDS-1 = left end), winner (00/01/10), tie (1-cycle pulse).
module tow_arena
    import tow_pkg::*;
#(
    parameter int N_LEDS       = 7,
    parameter int CLR_CYCLES   = 1000,
    parameter int FLASH_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pbl,
    input  logic              pbr,
    output logic [N_LEDS-1:0] leds_out,
    output logic [1:0]        winner,
    output logic              tie
);

    localparam int PW = $clog2(N_LEDS);
    localparam int CW = $clog2(CLR_CYCLES > 1 ? CLR_CYCLES : 2);
    localparam int FW = $clog2(FLASH_CYCLES > 1 ? FLASH_CYCLES : 2);

    localparam logic [PW-1:0]     CENTER     = PW'((N_LEDS - 1) / 2);
    localparam logic [PW-1:0]     LEFT_END   = PW'(N_LEDS - 1);
    localparam logic [CW-1:0]     CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [FW-1:0]     FLASH_LAST = FW'(FLASH_CYCLES - 1);
    localparam logic [N_LEDS-1:0] ONE_LED    = {{(N_LEDS-1){1'b0}}, 1'b1};

    state_t        state;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nxt;
    logic [CW-1:0] clr_cnt;
    logic [FW-1:0] flash_cnt;
    logic          flash_on;

    logic press_l;
    logic press_r;
    logic win_l;
    logic win_r;
    logic tie_now;

    tow_btn_sync u_sync_l (.clk(clk), .rst(rst), .pb(pbl), .press(press_l));
    tow_btn_sync u_sync_r (.clk(clk), .rst(rst), .pb(pbr), .press(press_r));

    // Round resolution. In CLEAR a lone press is a false start and hands the
    // round to the opponent; a simultaneous pair there is simply ignored.
    always_comb begin
        win_l   = 1'b0;
        win_r   = 1'b0;
        tie_now = 1'b0;
        case (state)
            CLEAR: begin
                if (press_l ^ press_r) begin
                    win_l = press_r;
                    win_r = press_l;
                end
            end
            ARMED: begin
                if (press_l && press_r) begin
                    tie_now = 1'b1;
                end else begin
                    win_l = press_l;
                    win_r = press_r;
                end
            end
            default: ;
        endcase

        // pos sits strictly inside the bar outside OVER; guards keep it clamped anyway.
        pos_nxt = pos;
        if (win_l && pos != LEFT_END) begin
            pos_nxt = pos + PW'(1);
        end else if (win_r && pos != '0) begin
            pos_nxt = pos - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            pos       <= CENTER;
            clr_cnt   <= '0;
            flash_cnt <= '0;
            flash_on  <= 1'b0;
            winner    <= W_NONE;
            tie       <= 1'b0;
        end else begin
            tie <= tie_now;
            case (state)
                CLEAR, ARMED: begin
                    if (win_l || win_r) begin
                        pos     <= pos_nxt;
                        clr_cnt <= '0;
                        if (pos_nxt == LEFT_END || pos_nxt == '0) begin
                            state     <= OVER;
                            winner    <= (pos_nxt == LEFT_END) ? W_LEFT : W_RIGHT;
                            flash_on  <= 1'b1;
                            flash_cnt <= '0;
                        end else begin
                            state <= CLEAR;
                        end
                    end else if (tie_now) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (state == CLEAR) begin
                        if (clr_cnt == CLR_LAST) begin
                            state   <= ARMED;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + CW'(1);
                        end
                    end
                end
                OVER: begin
                    if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        flash_on  <= ~flash_on;
                    end else begin
                        flash_cnt <= flash_cnt + FW'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_comb begin
        leds_out = '0;
        if (state == ARMED || (state == OVER && flash_on)) begin
            leds_out = ONE_LED << pos;
        end
    end

endmodule

// File: tb/tb_tow_arena.sv
module tb_tow_arena;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pbl = 1'b0;
    logic       pbr = 1'b0;
    logic [6:0] leds_out;
    logic [1:0] winner;
    logic       tie;

    int tests = 0;
    int fails = 0;

    tow_arena #(.N_LEDS(7), .CLR_CYCLES(4), .FLASH_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pbl      (pbl),
        .pbr      (pbr),
        .leds_out (leds_out),
        .winner   (winner),
        .tie      (tie)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic pass_clear();
        repeat (4) tick();
    endtask

    // One-cycle press; returns just after the decision edge.
    task automatic press_round(input logic l, input logic r);
        pbl = l;
        pbr = r;
        tick();
        pbl = 1'b0;
        pbr = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        pbl = 1'b0;
        pbr = 1'b0;
        rst = 1'b0;
        tick();
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL reset_leds: got %b expected 0000000", leds_out); end
        tests++; if (winner !== 2'b00) begin fails++; $display("FAIL reset_winner: got %b expected 00", winner); end
        tests++; if (tie !== 1'b0) begin fails++; $display("FAIL reset_tie: got %b expected 0", tie); end
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            logic [6:0] exp;
            tick();
            exp = (i == 4) ? 7'b0001000 : 7'b0000000;
            tests++; if (leds_out !== exp) begin fails++; $display("FAIL clear_to_armed[%0d]: got %b expected %b", i, leds_out, exp); end
        end
        tests++; if (winner !== 2'b00) begin fails++; $display("FAIL armed_winner: got %b expected 00", winner); end
    endtask

    task automatic test_press_left();
        pbl = 1'b1;
        tick();
        pbl = 1'b0;
        tests++; if (leds_out !== 7'b0001000) begin fails++; $display("FAIL latency_edge1: got %b expected 0001000", leds_out); end
        tick();
        tests++; if (leds_out !== 7'b0001000) begin fails++; $display("FAIL latency_edge2: got %b expected 0001000", leds_out); end
        tick();
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL latency_edge3: got %b expected 0000000", leds_out); end
        for (int i = 1; i <= 4; i++) begin
            logic [6:0] exp;
            tick();
            exp = (i == 4) ? 7'b0010000 : 7'b0000000;
            tests++; if (leds_out !== exp) begin fails++; $display("FAIL left_win_rearm[%0d]: got %b expected %b", i, leds_out, exp); end
        end
    endtask

    task automatic test_tie();
        do_reset();
        pass_clear();
        pbl = 1'b1;
        pbr = 1'b1;
        tick();
        pbl = 1'b0;
        pbr = 1'b0;
        tick();
        tests++; if (tie !== 1'b0) begin fails++; $display("FAIL tie_early: got %b expected 0", tie); end
        tick();
        tests++; if (tie !== 1'b1) begin fails++; $display("FAIL tie_pulse: got %b expected 1", tie); end
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL tie_to_clear: got %b expected 0000000", leds_out); end
        tick();
        tests++; if (tie !== 1'b0) begin fails++; $display("FAIL tie_width: got %b expected 0", tie); end
        tick();
        tick();
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL tie_clear_len: got %b expected 0000000", leds_out); end
        tick();
        tests++; if (leds_out !== 7'b0001000) begin fails++; $display("FAIL tie_pos_kept: got %b expected 0001000", leds_out); end
    endtask

    task automatic test_false_start();
        // Both buttons during CLEAR: ignored, counter still expires on time.
        do_reset();
        tick();
        pbl = 1'b1;
        pbr = 1'b1;
        tick();
        pbl = 1'b0;
        pbr = 1'b0;
        tick();
        tick();
        tests++; if (leds_out !== 7'b0001000) begin fails++; $display("FAIL clear_both_ignored: got %b expected 0001000", leds_out); end
        tests++; if (tie !== 1'b0) begin fails++; $display("FAIL clear_both_no_tie: got %b expected 0", tie); end
        // Tie in ARMED to land in CLEAR, then right jumps the gun.
        press_round(1'b1, 1'b1);
        press_round(1'b0, 1'b1);
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL false_start_clear: got %b expected 0000000", leds_out); end
        for (int i = 1; i <= 4; i++) begin
            logic [6:0] exp;
            tick();
            exp = (i == 4) ? 7'b0010000 : 7'b0000000;
            tests++; if (leds_out !== exp) begin fails++; $display("FAIL false_start_pos[%0d]: got %b expected %b", i, leds_out, exp); end
        end
    endtask

    task automatic test_hold();
        pbl = 1'b1;
        repeat (3) tick();
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL hold_press: got %b expected 0000000", leds_out); end
        pass_clear();
        tests++; if (leds_out !== 7'b0100000) begin fails++; $display("FAIL hold_pos5: got %b expected 0100000", leds_out); end
        repeat (5) tick();
        tests++; if (leds_out !== 7'b0100000) begin fails++; $display("FAIL hold_single: got %b expected 0100000", leds_out); end
        pbl = 1'b0;
        repeat (3) tick();
        tests++; if (leds_out !== 7'b0100000) begin fails++; $display("FAIL hold_release: got %b expected 0100000", leds_out); end
    endtask

    task automatic test_game_over();
        logic [6:0] armed_exp [2];
        armed_exp[0] = 7'b0010000;
        armed_exp[1] = 7'b0100000;
        do_reset();
        pass_clear();
        for (int w = 0; w < 3; w++) begin
            press_round(1'b1, 1'b0);
            if (w < 2) begin
                tests++; if (winner !== 2'b00) begin fails++; $display("FAIL mid_winner[%0d]: got %b expected 00", w, winner); end
                pass_clear();
                tests++; if (leds_out !== armed_exp[w]) begin fails++; $display("FAIL left_step[%0d]: got %b expected %b", w, leds_out, armed_exp[w]); end
            end
        end
        tests++; if (winner !== 2'b10) begin fails++; $display("FAIL left_winner: got %b expected 10", winner); end
        tests++; if (leds_out !== 7'b1000000) begin fails++; $display("FAIL over_lit: got %b expected 1000000", leds_out); end
        for (int i = 1; i <= 12; i++) begin
            logic [6:0] exp;
            pbr = (i >= 2 && i <= 4);
            pbl = (i >= 6 && i <= 7) || (i == 10);
            tick();
            exp = ((i % 4) < 2) ? 7'b1000000 : 7'b0000000;
            tests++; if (leds_out !== exp) begin fails++; $display("FAIL flash[%0d]: got %b expected %b", i, leds_out, exp); end
        end
        pbl = 1'b0;
        pbr = 1'b0;
        tests++; if (winner !== 2'b10) begin fails++; $display("FAIL over_winner_held: got %b expected 10", winner); end
    endtask

    task automatic test_right_win();
        do_reset();
        pass_clear();
        press_round(1'b0, 1'b1);
        pass_clear();
        tests++; if (leds_out !== 7'b0000100) begin fails++; $display("FAIL right_step: got %b expected 0000100", leds_out); end
        press_round(1'b0, 1'b1);
        pass_clear();
        press_round(1'b0, 1'b1);
        tests++; if (winner !== 2'b01) begin fails++; $display("FAIL right_winner: got %b expected 01", winner); end
        tests++; if (leds_out !== 7'b0000001) begin fails++; $display("FAIL right_end_lit: got %b expected 0000001", leds_out); end
        tick();
        tick();
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL right_end_dark: got %b expected 0000000", leds_out); end
    endtask

    task automatic test_reset_over();
        pbl = 1'b1;
        rst = 1'b0;
        tick();
        tests++; if (winner !== 2'b00) begin fails++; $display("FAIL over_reset_winner: got %b expected 00", winner); end
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL over_reset_leds: got %b expected 0000000", leds_out); end
        rst = 1'b1;
        pass_clear();
        tests++; if (leds_out !== 7'b0001000) begin fails++; $display("FAIL held_rst_armed: got %b expected 0001000", leds_out); end
        repeat (4) tick();
        tests++; if (leds_out !== 7'b0001000) begin fails++; $display("FAIL held_rst_no_press: got %b expected 0001000", leds_out); end
        pbl = 1'b0;
        repeat (2) tick();
        press_round(1'b1, 1'b0);
        tests++; if (leds_out !== 7'b0000000) begin fails++; $display("FAIL repress_taken: got %b expected 0000000", leds_out); end
        pass_clear();
        tests++; if (leds_out !== 7'b0010000) begin fails++; $display("FAIL repress_pos4: got %b expected 0010000", leds_out); end
    endtask

    initial begin
        test_reset();
        test_press_left();
        test_tie();
        test_false_start();
        test_hold();
        test_game_over();
        test_right_win();
        test_reset_over();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tow_arena.md
TOW_ARENA -- requirements
Module: tow_arena

Interface
REQ-001 Parameter N_LEDS, default 7, LED count; SHALL be odd and >= 3.
REQ-002 Parameter CLR_CYCLES, default 1000, length of the LEDs-off clear phase in clocks; SHALL be >= 1.
REQ-003 Parameter FLASH_CYCLES, default 500, half-period of the game-over flash in clocks; SHALL be >= 1.
REQ-004 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 pbl  input  1  left player pushbutton, asynchronous, active-high.
REQ-007 pbr  input  1  right player pushbutton, asynchronous, active-high.
REQ-008 leds_out  output  N_LEDS  LED bar; index N_LEDS-1 is the left end, index 0 the right end.
REQ-009 winner  output  2  game winner: 00 none, 01 right, 10 left; 11 SHALL never occur.
REQ-010 tie  output  1  one-cycle pulse on a tied round.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser and a rising-edge detector; only the edge is a "press".
REQ-012 A held button SHALL produce exactly one press.
REQ-013 Position pos SHALL be a register of clog2(N_LEDS) bits; CENTER = (N_LEDS-1)/2.
REQ-014 FSM states: CLEAR, ARMED, OVER.
REQ-015 CLEAR: leds_out = 0; a counter SHALL run for CLR_CYCLES clocks and then enter ARMED.
REQ-016 CLEAR, single press (false start): the opponent SHALL win the round.
REQ-017 CLEAR, both presses in the same cycle: the presses SHALL be ignored and the counter SHALL continue.
REQ-018 ARMED: leds_out SHALL be one-hot at pos.
REQ-019 ARMED, first single press: that player SHALL win the round.
REQ-020 ARMED, both presses in the same cycle: pos SHALL be unchanged, tie SHALL pulse for 1 cycle, and the FSM SHALL go to CLEAR.
REQ-021 Round won by left: pos+1; won by right: pos-1; the update SHALL occur in the same registered transition as the decision.
REQ-022 After the update: if pos = N_LEDS-1 or pos = 0, go to OVER; otherwise go to CLEAR with the counter reset to 0.
REQ-023 Latency: an ARMED press SHALL be visible on leds_out and state on the 3rd rising clk edge after the button is first sampled high.
REQ-024 OVER: winner SHALL latch 10 if pos = N_LEDS-1 and 01 if pos = 0.
REQ-025 OVER: leds_out SHALL carry only the end LED, toggling every FLASH_CYCLES clocks and starting lit.
REQ-026 OVER: buttons SHALL be ignored; exit SHALL be by reset only.
REQ-027 pos SHALL never wrap and never leave 0..N_LEDS-1.
REQ-028 winner SHALL be 00 in every state except OVER.

Reset
REQ-029 rst=0 sampled at a clk edge: state = CLEAR, pos = CENTER, counters = 0, synchroniser and edge flops = 0, leds_out = 0, winner = 00, tie = 0.
REQ-030 Reset asserted mid-round or in OVER SHALL take effect at the next edge, with no residual press.
REQ-031 A button held through reset release SHALL produce no press until it is released and pressed again.

Structure
REQ-032 Shared package tow_pkg SHALL hold the state enum (CLEAR, ARMED, OVER) and the winner encodings (W_NONE, W_RIGHT, W_LEFT).
REQ-033 Sub-module tow_btn_sync (2-flop synchroniser + edge detect) SHALL be instantiated once per button.
REQ-034 Counter widths SHALL derive from the parameters via clog2.

Verification (N_LEDS=7, CLR_CYCLES=4, FLASH_CYCLES=2)
REQ-035 Reset, 4 clocks idle -> leds_out 0000000 during CLEAR, then 0001000 in ARMED; winner 00.
REQ-036 ARMED, pbl pulsed -> leds_out 0000000 on the 3rd edge, then 0010000 when next ARMED.
REQ-037 pbl and pbr rise in the same cycle in ARMED -> tie high exactly 1 cycle, pos stays 3, FSM to CLEAR.
REQ-038 pbr pressed during CLEAR -> false start, pos 3->4 (left gains).
REQ-039 Three left wins from reset -> pos 6, winner 10, leds_out toggles 1000000/0000000 every 2 clocks, presses ignored.
REQ-040 rst=0 in OVER with pbl held -> next edge: pos 3, winner 00; no press until pbl is released and re-pressed.
